// File: rtl/radio_slot_if.sv
// Burst request/response bundle between the link controller (master) and the
// radio slot sequencer (slave).
interface radio_slot_if;
  logic [9:0]  regi_pllsetuptime;
  logic        tx_req_p;
  logic        rx_req_p;
  logic [6:0]  req_fk;
  logic [11:0] req_len;
  logic        abort_p;
  logic [6:0]  lc_fk;
  logic        loadfreq_p;
  logic        txen;
  logic        rxen;
  logic        bit_p;
  logic        busy;
  logic        done_p;
  logic        req_drop_p;

  modport master (
    output regi_pllsetuptime, tx_req_p, rx_req_p, req_fk, req_len, abort_p,
    input  lc_fk, loadfreq_p, txen, rxen, bit_p, busy, done_p, req_drop_p
  );

  modport slave (
    input  regi_pllsetuptime, tx_req_p, rx_req_p, req_fk, req_len, abort_p,
    output lc_fk, loadfreq_p, txen, rxen, bit_p, busy, done_p, req_drop_p
  );
endinterface

// File: rtl/radio_slot_seq.sv
// Per-burst radio sequencer: synthesizer load, PLL settle wait, then a TX/RX
// window of L bit periods with a bit strobe. Every output is a flop.
module radio_slot_seq #(
  parameter int CLKS_PER_US = 6
) (
  input logic         clk_6M,
  input logic         rstz,
  radio_slot_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, ACTIVE} state_t;

  localparam logic [12:0] SETTLE_K = 13'(CLKS_PER_US);
  localparam logic [2:0]  SUB_LAST = 3'(CLKS_PER_US - 1);

  state_t      state, state_nxt;
  logic        tx_dir, tx_dir_nxt;
  logic [6:0]  fk_nxt;
  logic [11:0] len_q, len_nxt;
  logic [9:0]  pll_q, pll_nxt;
  logic [12:0] settle_cnt, settle_nxt;
  logic [2:0]  sub_cnt, sub_nxt;
  logic [11:0] bit_cnt, bits_nxt;
  logic        done_nxt, drop_nxt;
  logic        any_req, start_active, finish;
  logic        loadfreq_nxt, txen_nxt, rxen_nxt, bit_nxt, busy_nxt;

  always_comb begin
    state_nxt    = state;
    tx_dir_nxt   = tx_dir;
    fk_nxt       = bus.lc_fk;
    len_nxt      = len_q;
    pll_nxt      = pll_q;
    settle_nxt   = settle_cnt;
    sub_nxt      = sub_cnt;
    bits_nxt     = bit_cnt;
    done_nxt     = 1'b0;
    drop_nxt     = 1'b0;
    start_active = 1'b0;
    finish       = 1'b0;
    any_req      = bus.tx_req_p | bus.rx_req_p;

    case (state)
      IDLE: begin
        // TX wins a tie; the losing RX request is reported as dropped.
        if (!bus.abort_p && any_req) begin
          state_nxt  = LOAD;
          tx_dir_nxt = bus.tx_req_p;
          fk_nxt     = bus.req_fk;
          len_nxt    = bus.req_len;
          pll_nxt    = bus.regi_pllsetuptime;
          drop_nxt   = bus.tx_req_p & bus.rx_req_p;
        end
      end
      LOAD: begin
        settle_nxt = 13'(pll_q) * SETTLE_K;
        if (pll_q == 10'd0) begin
          if (len_q == 12'd0) finish = 1'b1;
          else start_active = 1'b1;
        end else begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 13'd1) begin
          if (len_q == 12'd0) finish = 1'b1;
          else start_active = 1'b1;
        end else begin
          settle_nxt = settle_cnt - 13'd1;
        end
      end
      ACTIVE: begin
        if (sub_cnt == SUB_LAST) begin
          if (bit_cnt == 12'd1) begin
            finish = 1'b1;
          end else begin
            bits_nxt = bit_cnt - 12'd1;
            sub_nxt  = 3'd0;
          end
        end else begin
          sub_nxt = sub_cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_active) begin
      state_nxt = ACTIVE;
      sub_nxt   = 3'd0;
      bits_nxt  = len_q;
    end
    if (finish) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end

    // Abort overrides everything, including a normal completion in the same cycle.
    if (state != IDLE) begin
      drop_nxt = any_req;
      if (bus.abort_p) begin
        state_nxt = IDLE;
        done_nxt  = 1'b0;
      end
    end

    loadfreq_nxt = (state_nxt == LOAD);
    txen_nxt     = (state_nxt == ACTIVE) &  tx_dir_nxt;
    rxen_nxt     = (state_nxt == ACTIVE) & ~tx_dir_nxt;
    bit_nxt      = (state_nxt == ACTIVE) & (sub_nxt == SUB_LAST);
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state          <= IDLE;
      tx_dir         <= 1'b0;
      len_q          <= '0;
      pll_q          <= '0;
      settle_cnt     <= '0;
      sub_cnt        <= '0;
      bit_cnt        <= '0;
      bus.lc_fk      <= '0;
      bus.loadfreq_p <= 1'b0;
      bus.txen       <= 1'b0;
      bus.rxen       <= 1'b0;
      bus.bit_p      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done_p     <= 1'b0;
      bus.req_drop_p <= 1'b0;
    end else begin
      state          <= state_nxt;
      tx_dir         <= tx_dir_nxt;
      len_q          <= len_nxt;
      pll_q          <= pll_nxt;
      settle_cnt     <= settle_nxt;
      sub_cnt        <= sub_nxt;
      bit_cnt        <= bits_nxt;
      bus.lc_fk      <= fk_nxt;
      bus.loadfreq_p <= loadfreq_nxt;
      bus.txen       <= txen_nxt;
      bus.rxen       <= rxen_nxt;
      bus.bit_p      <= bit_nxt;
      bus.busy       <= busy_nxt;
      bus.done_p     <= done_nxt;
      bus.req_drop_p <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_radio_slot_seq.sv
// Self-checking bench for radio_slot_seq: a burst-timeline model checked every
// cycle, directed scenarios pinned with literal cycle numbers, then random traffic.
module tb_radio_slot_seq;
  localparam int K = 6;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  always #5 clk_6M = ~clk_6M;

  radio_slot_if bus();

  radio_slot_seq #(.CLKS_PER_US(K)) dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // A burst is described by its LOAD cycle and its last busy cycle.
  logic        m_active = 1'b0;
  logic        m_tx     = 1'b0;
  logic [6:0]  m_fk     = '0;
  int          m_start  = 0;
  int          m_end    = -10;
  int          m_p      = 0;
  int          m_l      = 0;
  logic [13:0] exp_vec  = '0;

  function automatic logic busy_at(input int c);
    return m_active && (c >= m_start) && (c <= m_end);
  endfunction

  always @(posedge clk_6M) begin
    int   c, t;
    logic e_drop, e_load, e_act, e_bit, e_busy, e_done;
    cyc++;
    c      = cyc;
    e_drop = 1'b0;
    if (!rstz) begin
      m_active = 1'b0;
      m_fk     = '0;
    end else if (busy_at(c - 1)) begin
      if (bus.tx_req_p || bus.rx_req_p) e_drop = 1'b1;
      if (bus.abort_p) m_active = 1'b0;
    end else if (!bus.abort_p && (bus.tx_req_p || bus.rx_req_p)) begin
      m_active = 1'b1;
      m_tx     = bus.tx_req_p;
      m_fk     = bus.req_fk;
      m_p      = int'(bus.regi_pllsetuptime);
      m_l      = int'(bus.req_len);
      m_start  = c;
      m_end    = c + K * m_p + K * m_l;
      e_drop   = bus.tx_req_p & bus.rx_req_p;
    end
    t      = c - m_start;
    e_busy = busy_at(c);
    e_load = m_active && (t == 0);
    e_act  = m_active && (t > K * m_p) && (t <= K * m_p + K * m_l);
    e_bit  = e_act && (((t - K * m_p) % K) == 0);
    e_done = m_active && (c == m_end + 1);
    exp_vec = {m_fk, e_load, e_act & m_tx, e_act & ~m_tx, e_bit, e_busy, e_done, e_drop};
  end

  // Event monitor used for the literal per-scenario expectations.
  int mark = 0;
  int first_load, last_load, n_load, fk_at_load;
  int first_tx, last_tx, n_tx, first_rx, last_rx, n_rx;
  int n_bit, last_bit, n_done, first_done, last_done;
  int n_drop, first_drop, last_busy;

  task automatic clearMon();
    first_load = -1; last_load = -1; n_load = 0; fk_at_load = -1;
    first_tx = -1; last_tx = -1; n_tx = 0; first_rx = -1; last_rx = -1; n_rx = 0;
    n_bit = 0; last_bit = -1; n_done = 0; first_done = -1; last_done = -1;
    n_drop = 0; first_drop = -1; last_busy = -1;
  endtask

  always @(negedge clk_6M) begin
    int rel;
    logic [13:0] act_vec;
    if (cyc >= 1) begin
      act_vec = {bus.lc_fk, bus.loadfreq_p, bus.txen, bus.rxen, bus.bit_p,
                 bus.busy, bus.done_p, bus.req_drop_p};
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL cycle_outputs cycle=%0d actual=%h expected=%h", cyc, act_vec, exp_vec);
      end
      rel = cyc - mark;
      if (bus.loadfreq_p) begin
        if (first_load < 0) first_load = rel;
        last_load = rel; n_load++; fk_at_load = int'(bus.lc_fk);
      end
      if (bus.txen) begin if (first_tx < 0) first_tx = rel; last_tx = rel; n_tx++; end
      if (bus.rxen) begin if (first_rx < 0) first_rx = rel; last_rx = rel; n_rx++; end
      if (bus.bit_p) begin n_bit++; last_bit = rel; end
      if (bus.done_p) begin if (first_done < 0) first_done = rel; last_done = rel; n_done++; end
      if (bus.req_drop_p) begin if (first_drop < 0) first_drop = rel; n_drop++; end
      if (bus.busy) last_busy = rel;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic stepN(input int n);
    repeat (n) step();
  endtask

  // Drives one request/abort for the current cycle, then scrambles the sampled fields.
  task automatic applyStimulus(input logic tx, input logic rx, input logic ab,
                               input logic [6:0] fk, input logic [11:0] len,
                               input logic [9:0] p);
    bus.tx_req_p          = tx;
    bus.rx_req_p          = rx;
    bus.abort_p           = ab;
    bus.req_fk            = fk;
    bus.req_len           = len;
    bus.regi_pllsetuptime = p;
    step();
    bus.tx_req_p          = 1'b0;
    bus.rx_req_p          = 1'b0;
    bus.abort_p           = 1'b0;
    bus.req_fk            = 7'($urandom_range(0, 127));
    bus.req_len           = 12'($urandom_range(0, 4095));
    bus.regi_pllsetuptime = 10'($urandom_range(0, 1023));
  endtask

  initial begin
    bus.tx_req_p = 1'b0; bus.rx_req_p = 1'b0; bus.abort_p = 1'b0;
    bus.req_fk = '0; bus.req_len = '0; bus.regi_pllsetuptime = '0;
    clearMon();
    stepN(3);
    rstz = 1'b1;
    step();
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_lc_fk", int'(bus.lc_fk), 0);
    checkOutput("reset_enables", int'({bus.txen, bus.rxen, bus.loadfreq_p, bus.bit_p}), 0);
    checkOutput("reset_pulses", int'({bus.done_p, bus.req_drop_p}), 0);

    $display("[TB] normal TX burst");
    clearMon(); mark = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h27, 12'd366, 10'd150);
    stepN(3105);
    checkOutput("tx_load_cycle", first_load, 1);
    checkOutput("tx_load_fk", fk_at_load, 'h27);
    checkOutput("tx_first_en", first_tx, 902);
    checkOutput("tx_last_en", last_tx, 3097);
    checkOutput("tx_bit_count", n_bit, 366);
    checkOutput("tx_last_bit", last_bit, 3097);
    checkOutput("tx_done_cycle", first_done, 3098);
    checkOutput("tx_rx_never", n_rx, 0);

    $display("[TB] simultaneous requests");
    clearMon(); mark = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd5, 12'd1, 10'd0);
    stepN(12);
    checkOutput("sim_drop_cycle", first_drop, 1);
    checkOutput("sim_first_tx", first_tx, 2);
    checkOutput("sim_last_tx", last_tx, 7);
    checkOutput("sim_rx_never", n_rx, 0);
    checkOutput("sim_done_cycle", first_done, 8);

    $display("[TB] abort during RX");
    clearMon(); mark = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 7'h4e, 12'd100, 10'd10);
    stepN(199);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 12'd0, 10'd0);
    stepN(20);
    checkOutput("abort_first_rx", first_rx, 62);
    checkOutput("abort_last_rx", last_rx, 200);
    checkOutput("abort_last_busy", last_busy, 200);
    checkOutput("abort_no_done", n_done, 0);
    checkOutput("abort_lc_fk", int'(bus.lc_fk), 'h4e);

    $display("[TB] busy rejection and back-to-back");
    clearMon(); mark = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd11, 12'd3, 10'd2);
    stepN(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 7'd60, 12'd9, 10'd1);
    stepN(26);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd12, 12'd2, 10'd0);
    stepN(20);
    checkOutput("b2b_drop_cycle", first_drop, 6);
    checkOutput("b2b_drop_count", n_drop, 1);
    checkOutput("b2b_first_tx", first_tx, 14);
    checkOutput("b2b_first_done", first_done, 32);
    checkOutput("b2b_second_load", last_load, 33);
    checkOutput("b2b_second_fk", fk_at_load, 12);
    checkOutput("b2b_tx_cycles", n_tx, 30);
    checkOutput("b2b_bits", n_bit, 5);
    checkOutput("b2b_last_done", last_done, 46);
    checkOutput("b2b_rx_never", n_rx, 0);

    $display("[TB] zero length");
    clearMon(); mark = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 7'd78, 12'd0, 10'd1);
    stepN(12);
    checkOutput("zero_load_cycle", first_load, 1);
    checkOutput("zero_no_enable", n_tx + n_rx, 0);
    checkOutput("zero_no_bit", n_bit, 0);
    checkOutput("zero_done_cycle", first_done, 8);

    $display("[TB] reset mid-ACTIVE");
    clearMon(); mark = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd33, 12'd5, 10'd0);
    stepN(9);
    rstz = 1'b0;
    step();
    rstz = 1'b1;
    checkOutput("rst_lc_fk", int'(bus.lc_fk), 0);
    checkOutput("rst_outputs", int'({bus.loadfreq_p, bus.txen, bus.rxen, bus.bit_p,
                                     bus.busy, bus.done_p, bus.req_drop_p}), 0);
    clearMon(); mark = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 7'd9, 12'd2, 10'd0);
    stepN(20);
    checkOutput("cold_load_fk", fk_at_load, 9);
    checkOutput("cold_first_rx", first_rx, 2);
    checkOutput("cold_last_rx", last_rx, 13);
    checkOutput("cold_done_cycle", first_done, 14);

    $display("[TB] random traffic");
    for (int i = 0; i < 9000; i++) begin
      bus.tx_req_p          = ($urandom_range(0, 19) == 0);
      bus.rx_req_p          = ($urandom_range(0, 19) == 0);
      bus.abort_p           = ($urandom_range(0, 59) == 0);
      bus.req_fk            = 7'($urandom_range(0, 78));
      bus.req_len           = 12'($urandom_range(0, 12));
      bus.regi_pllsetuptime = 10'($urandom_range(0, 4));
      rstz                  = ($urandom_range(0, 999) != 0);
      step();
    end
    bus.tx_req_p = 1'b0; bus.rx_req_p = 1'b0; bus.abort_p = 1'b0;
    rstz = 1'b1;
    stepN(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/radio_slot_seq.md
# radio_slot_seq

Per-burst radio front-end sequencer between the link controller and the radio model/PHY.
- Accepts one TX or RX burst request, each carrying a hop channel and a burst length in bits.
- Loads the synthesizer frequency, waits out the programmed PLL setup time, then holds `txen` or `rxen` for exactly the requested number of 1 Mb/s bit periods, with a bit strobe.
- Arbitrates simultaneous TX and RX requests and supports abort at any point.

## Interface
Parameters:
- `CLKS_PER_US`, default 6: clk_6M cycles per microsecond and per bit period.

Ports:
- `clk_6M` in 1: single clock; all logic is on its rising edge.
- `rstz` in 1: reset, synchronous and active-low.
- `regi_pllsetuptime` in 10: PLL settle time in µs. Sampled at request acceptance.
- `tx_req_p` in 1: one-cycle TX burst request.
- `rx_req_p` in 1: one-cycle RX burst request.
- `req_fk` in 7: hop channel 0..78. Sampled with the accepted request.
- `req_len` in 12: burst length in bits. Sampled with the accepted request.
- `abort_p` in 1: one-cycle abort.
- `lc_fk` out 7: latched channel of the current or last burst.
- `loadfreq_p` out 1: one-cycle synthesizer load strobe.
- `txen` out 1: transmit window.
- `rxen` out 1: receive window.
- `bit_p` out 1: strobe on the last clock of each active bit period.
- `busy` out 1: sequencer not IDLE.
- `done_p` out 1: burst completed normally.
- `req_drop_p` out 1: a request was rejected.

## Operation
- States: IDLE, LOAD, SETTLE, ACTIVE.
- IDLE:
  - If `abort_p`=1, ignore all requests and raise no drop.
  - Otherwise a request moves the FSM to LOAD. The block latches direction, `req_fk` into `lc_fk`, `req_len`, and `regi_pllsetuptime`.
  - If TX and RX requests arrive together, TX wins; the RX request is dropped with `req_drop_p`=1.
- LOAD lasts one cycle with `loadfreq_p`=1, then moves to SETTLE.
  - If the latched setup time P=0, LOAD goes directly to ACTIVE.
- SETTLE:
  - A 13-bit down-counter is loaded with P×CLKS_PER_US.
  - The FSM leaves SETTLE after P×6 cycles.
  - It goes to ACTIVE, or to IDLE with `done_p` if the latched length L=0.
- ACTIVE:
  - `txen` or `rxen` (never both) is high.
  - A 3-bit subcounter wraps at CLKS_PER_US and a 12-bit bit counter counts down from L.
  - `bit_p` pulses when the subcounter wraps.
  - After the L-th `bit_p` the FSM returns to IDLE, with `done_p`=1 in the first IDLE cycle.
- Any request seen while `busy`=1 is ignored, with `req_drop_p`=1 the next cycle.
- `abort_p` in any non-IDLE state:
  - IDLE the next cycle, with `txen`/`rxen`/`loadfreq_p`/`bit_p` low.
  - No `done_p`.
  - `lc_fk` is retained.
  - Abort takes priority over a coincident request; that request is dropped, not queued.
- A new request may be sampled in the same cycle `done_p` is high; `busy` re-asserts the next cycle.
- Reset values: `lc_fk`=0; `loadfreq_p`, `txen`, `rxen`, `bit_p`, `busy`, `done_p`, `req_drop_p` all 0; FSM in IDLE; counters 0.
- Reset asserted mid-burst has the same effect as abort on the next edge, with `lc_fk` cleared.

## Timing
- Cycle n is the period after rising edge n. The request is sampled at edge 0.
- Cycle 1: LOAD. `busy`=1, `loadfreq_p`=1, `lc_fk` valid.
- Cycles 2 .. 6P+1: SETTLE.
- Cycles 6P+2 .. 6P+6L+1: ACTIVE, with enable high.
  - `bit_p` is high at cycles 6P+1+6k, for k=1..L.
- Cycle 6P+6L+2: IDLE. `done_p`=1, `busy`=0.
- `req_drop_p` follows the rejected request by one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Normal TX:**
  - Stimulus: P=150, `tx_req_p` with fk=0x27, L=366.
  - Response: `loadfreq_p` at cycle 1 with `lc_fk`=0x27; `txen` over cycles 902..3097; 366 `bit_p` pulses, last at cycle 3097; `done_p` at 3098.
- **Simultaneous requests:**
  - Stimulus: `tx_req_p`=`rx_req_p`=1, P=0, L=1.
  - Response: TX burst; `req_drop_p` at cycle 1; `txen` cycles 2..7; `rxen` never high; `done_p` at 8.
- **Abort:**
  - Stimulus: RX burst with P=10, L=100; `abort_p` at cycle 200.
  - Response: `rxen` low and `busy`=0 from cycle 201; no `done_p`; `lc_fk` unchanged.
- **Busy rejection and back-to-back:**
  - Stimulus: `rx_req_p` during SETTLE of a TX burst, then a TX request in the `done_p` cycle.
  - Response: the RX request gets `req_drop_p` one cycle later and the TX burst is unaffected; the second burst's LOAD occurs the cycle after `done_p`.
- **Zero length:**
  - Stimulus: L=0, P=1.
  - Response: `loadfreq_p` at cycle 1; no enable and no `bit_p`; `done_p` at cycle 8.
- **Reset mid-ACTIVE:**
  - Stimulus: `rstz`=0 for one edge during ACTIVE.
  - Response: all outputs 0 after that edge, including `lc_fk`; the next request behaves as from cold start.
